// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD event counter and its decade cells.
package counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_MAX            = 4'd9;
  localparam int unsigned DEFAULT_NUM_DIGITS = 6;

  function automatic bcd_digit_t clamp_bcd(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // A divide-by-1 prescaler still needs one bit to stay a legal vector.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_event_counter_decade.sv
// One BCD decade: steps when carry_in is set and inc or dec is strobed,
// reporting carry/borrow to the next decade in the same cycle.
module bcd_decade
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    carry_out  = inc && carry_in && (digit_q == BCD_MAX);
    borrow_out = dec && carry_in && (digit_q == '0);
  end

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = clamp_bcd(load_digit);
    end else if (carry_in && inc) begin
      digit_d = (digit_q == BCD_MAX) ? bcd_digit_t'(0) : digit_q + 4'd1;
    end else if (carry_in && dec) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-decade up/down BCD counter advanced by a prescaled tick, with load,
// clear, leading-zero blanking and a rollover pulse.
module bcd_event_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_DIGITS*4-1:0] load_value,
  output logic [NUM_DIGITS*4-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    tick,
  output logic                    wrap
);

  localparam int unsigned       PRESC_W    = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               wrap_q, wrap_d;
  logic               tick_w;
  logic               step_up, step_dn;
  logic [NUM_DIGITS:0] chain;
  logic [NUM_DIGITS-1:0] carry_w, borrow_w;
  bcd_digit_t         digit_w [NUM_DIGITS];

  // Gated by reset so a divide-by-1 prescaler cannot tick while held in reset.
  assign tick_w  = enable && !reset && (presc_q == PRESC_LAST);
  assign step_up = tick_w && up_down  && !clear && !load;
  assign step_dn = tick_w && !up_down && !clear && !load;

  always_comb begin
    presc_d = presc_q;
    if (clear || load) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = tick_w ? '0 : presc_q + 1'b1;
    end
  end

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_decade
    bcd_decade u_decade (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[i*4 +: 4]),
      .inc        (step_up),
      .dec        (step_dn),
      .carry_in   (chain[i]),
      .digit      (digit_w[i]),
      .carry_out  (carry_w[i]),
      .borrow_out (borrow_w[i])
    );
    assign chain[i+1]        = carry_w[i] | borrow_w[i];
    assign bcd_out[i*4 +: 4] = digit_w[i];
  end

  // A ripple out of the top decade means the whole count rolled over.
  assign wrap_d = chain[NUM_DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (digit_w[i] == '0);
      blank[i] = zero_run;
    end
  end

  assign tick = tick_w;
  assign wrap = wrap_q;

endmodule
